// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a memory-stage requester and dmem_ctrl.
// The requester uses the master modport and the controller uses the slave modport.
interface dmem_ctrl_if;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic        ram_we_i;
    logic        ram_re_i;
    logic [31:0] ram_data_o;
    logic        ready_o;
    logic        err_o;
    logic [31:0] rd_cnt_o;
    logic [31:0] wr_cnt_o;

    modport master (
        output ram_addr_i, ram_data_i, ram_we_i, ram_re_i,
        input  ram_data_o, ready_o, err_o, rd_cnt_o, wr_cnt_o
    );

    modport slave (
        input  ram_addr_i, ram_data_i, ram_we_i, ram_re_i,
        output ram_data_o, ready_o, err_o, rd_cnt_o, wr_cnt_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Fixed-latency data-memory controller: latches one request, waits LATENCY cycles, then pulses ready_o.
// Optional macro DMEM_STATS_EN adds completed-read/write counters; without it both counters read 0.
module dmem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input logic       clk_i,
    input logic       rst_n_i,
    dmem_ctrl_if.slave bus
);

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("dmem_ctrl: LATENCY must be in the range 1..7");
    end

    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic                is_write_q;
    logic                in_range_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_q [2**ADDR_W];
    logic                accept;
    logic                access;
    logic                unused_addr_bits;

    assign accept = (state_q == S_IDLE) && (bus.ram_we_i || bus.ram_re_i);
    assign access = (state_q == S_WAIT) && (cnt_q == 3'd0);
    assign unused_addr_bits = ^bus.ram_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A simultaneous write and read request is taken as a write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            in_range_q <= 1'b0;
        end else if (accept) begin
            idx_q      <= bus.ram_addr_i[ADDR_W+1:2];
            wdata_q    <= bus.ram_data_i;
            is_write_q <= bus.ram_we_i;
            in_range_q <= (bus.ram_addr_i[31:ADDR_W+2] == '0);
        end
    end

    // The array has no reset; an aborted access never reaches the S_WAIT exit edge.
    always_ff @(posedge clk_i) begin
        if (access && is_write_q && in_range_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= 32'd0;
        end else if (access) begin
            if (!in_range_q) begin
                rdata_q <= 32'd0;
            end else if (!is_write_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    assign bus.ram_data_o = rdata_q;
    assign bus.ready_o    = (state_q == S_RESP);
    assign bus.err_o      = (state_q == S_RESP) && !in_range_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (state_q == S_RESP) begin
            if (is_write_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign bus.rd_cnt_o = rd_cnt_q;
    assign bus.wr_cnt_o = wr_cnt_q;
`else
    assign bus.rd_cnt_o = 32'd0;
    assign bus.wr_cnt_o = 32'd0;
`endif

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL provide parameter LATENCY, default 3, wait cycles per access; legal range 1..7, any other value raises an elaboration-time error.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 ram_addr_i  input  32  byte address from the memory stage.
REQ-006 ram_data_i  input  32  write data, already byte-merged by the requester.
REQ-007 ram_we_i  input  1  write request, held until ready_o.
REQ-008 ram_re_i  input  1  read request, held until ready_o.
REQ-009 ram_data_o  output  32  read data, registered.
REQ-010 ready_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  out-of-range flag, valid with ready_o.
REQ-012 rd_cnt_o, wr_cnt_o  output  32 each  completed-access counters (see Configuration).

Function
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-014 IDLE: if ram_we_i or ram_re_i, latch address, data and op, load cnt = LATENCY-1, go WAIT; else stay.
REQ-015 If ram_we_i and ram_re_i are both high in IDLE, the write SHALL win; the read is dropped.
REQ-016 WAIT: decrement cnt each cycle; in the cycle with cnt==0, perform the access at the closing edge and go RESP; WAIT lasts exactly LATENCY cycles.
REQ-017 Word index SHALL be latched ram_addr_i[ADDR_W+1:2]; address bits [1:0] are ignored.
REQ-018 Access is in range iff latched ram_addr_i[31:ADDR_W+2] == 0.
REQ-019 In-range write SHALL update the array at the WAIT exit edge.
REQ-020 In-range read SHALL load ram_data_o at the WAIT exit edge.
REQ-021 Out-of-range access SHALL leave the array unchanged, load ram_data_o = 0, and set err_o.
REQ-022 RESP: ready_o = 1 for exactly one cycle; request inputs ignored; next state IDLE unconditionally.
REQ-023 Latency: request sampled at edge E0 -> ready_o high in cycle LATENCY+1 after E0 (LATENCY=3 -> 4th cycle).
REQ-024 Input changes during WAIT/RESP SHALL have no effect; latched values are used.
REQ-025 Back-to-back: a request held after RESP SHALL be accepted in IDLE one cycle later; minimum access period is LATENCY+2 cycles.
REQ-026 ram_data_o SHALL hold its value across writes and until the next read completes.
REQ-027 err_o SHALL equal 0 whenever ready_o is 0.

Reset
REQ-028 On rst_n_i low, asynchronously: FSM = IDLE, cnt = 0, ram_data_o = 0, ready_o = 0, err_o = 0, counters = 0.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 Reset during WAIT SHALL abort the access; a pending write is discarded; no ready_o pulse follows.

Configuration
REQ-031 Macro DMEM_STATS_EN: when defined, rd_cnt_o / wr_cnt_o each increment by 1 at every RESP for completed reads / writes, including out-of-range ones, and wrap at 2^32.
REQ-032 Without DMEM_STATS_EN, rd_cnt_o and wr_cnt_o SHALL be constant 0 and no counter flops are built.

Verification
REQ-033 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ready_o in 4th cycle after each request; read returns 0xDEADBEEF; err_o = 0.
REQ-034 Read 0x0000_1000 (ADDR_W=10) -> ram_data_o = 0, err_o = 1 with ready_o; array unchanged.
REQ-035 Assert ram_we_i and ram_re_i together, addr 0x8, data 0x12345678 -> write performed; a later read of 0x8 returns 0x12345678; wr_cnt_o +1, rd_cnt_o unchanged.
REQ-036 Pull rst_n_i low in 2nd WAIT cycle of a write of 0xCAFEF00D to 0x4 over prior 0x1 -> no ready_o; a later read of 0x4 returns 0x1.
REQ-037 Hold ram_re_i high continuously with LATENCY=1 -> ready_o pulses every 3 cycles.
REQ-038 With DMEM_STATS_EN, 5 reads and 3 writes -> rd_cnt_o = 5, wr_cnt_o = 3; without it, both remain 0.
